// File: rtl/exception_controller_pkg.sv
// Shared definitions for the exception controller: cause codes, FSM states
// and a helper that classifies decode-stage cause codes.
// Optional feature macro used by the top: EXC_VECTORED_EN.
package exception_controller_pkg;

    localparam logic [2:0] CAUSE_EXT     = 3'b000;
    localparam logic [2:0] CAUSE_ILLEGAL = 3'b001;
    localparam logic [2:0] CAUSE_OVF     = 3'b010;
    localparam logic [2:0] CAUSE_SYSCALL = 3'b011;
    localparam logic [2:0] CAUSE_NONE    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } exc_state_e;

    // Only illegal and syscall are real decode-stage events; every other
    // code (including the reserved ones) counts as "none".
    function automatic logic is_step3_event(input logic [2:0] cause);
        return (cause == CAUSE_ILLEGAL) || (cause == CAUSE_SYSCALL);
    endfunction

endpackage

// File: rtl/exception_controller_exc_prio_enc.sv
// Age-ordered priority encoder for exception sources. Purely combinational:
// the execute stage holds the oldest instruction, then decode, then the
// external interrupt, which is only accepted against a real step3 instruction.
module exc_prio_enc
    import exception_controller_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [2:0]      cause_step3_i,
    input  logic [PC_W-1:0] pc_step3_i,
    input  logic            valid_step3_i,
    input  logic [2:0]      cause_step4_i,
    input  logic [PC_W-1:0] pc_step4_i,
    input  logic            ext_irq_i,
    output logic            take_o,
    output logic [2:0]      sel_cause_o,
    output logic [PC_W-1:0] sel_epc_o
);

    // Select the oldest pending event and the PC to resume at.
    always_comb begin
        take_o      = 1'b0;
        sel_cause_o = CAUSE_NONE;
        sel_epc_o   = '0;
        if (cause_step4_i != CAUSE_NONE) begin
            take_o      = 1'b1;
            sel_cause_o = cause_step4_i;
            sel_epc_o   = pc_step4_i;
        end else if (is_step3_event(cause_step3_i)) begin
            take_o      = 1'b1;
            sel_cause_o = cause_step3_i;
            // A syscall resumes after itself; illegal re-points at the fault.
            sel_epc_o   = (cause_step3_i == CAUSE_SYSCALL) ? pc_step3_i + PC_W'(4)
                                                           : pc_step3_i;
        end else if (ext_irq_i && valid_step3_i) begin
            take_o      = 1'b1;
            sel_cause_o = CAUSE_EXT;
            sel_epc_o   = pc_step3_i;
        end
    end

endmodule

// File: rtl/exception_controller.sv
// Central exception/interrupt sequencer: takes an event, flushes the pipe for
// FLUSH_CYCLES cycles, redirects to the handler and returns to EPC on eret.
// Optional feature macro: EXC_VECTORED_EN (per-cause 16-byte handler slots).
module exception_controller
    import exception_controller_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(32'h0000_0080),
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ext_irq,
    input  logic [2:0]      cause_step3,
    input  logic [PC_W-1:0] pc_step3,
    input  logic            valid_step3,
    input  logic [2:0]      cause_step4,
    input  logic [PC_W-1:0] pc_step4,
    input  logic            eret,
    output logic            interrupts_signal,
    output logic            flush_pipe,
    output logic            pc_redirect,
    output logic [PC_W-1:0] pc_redirect_addr,
    output logic [PC_W-1:0] epc,
    output logic [2:0]      cause_reg,
    output logic            in_handler,
    output logic            double_fault,
    output logic [1:0]      state_dbg
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    exc_state_e      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [2:0]      cause_q, cause_d;
    logic            df_q, df_d;

    logic            take;
    logic [2:0]      sel_cause;
    logic [PC_W-1:0] sel_epc;
    logic            sync_cause;
    logic [PC_W-1:0] handler_addr;

    exc_prio_enc #(.PC_W(PC_W)) u_prio (
        .cause_step3_i (cause_step3),
        .pc_step3_i    (pc_step3),
        .valid_step3_i (valid_step3),
        .cause_step4_i (cause_step4),
        .pc_step4_i    (pc_step4),
        .ext_irq_i     (ext_irq),
        .take_o        (take),
        .sel_cause_o   (sel_cause),
        .sel_epc_o     (sel_epc)
    );

    // Synchronous causes seen while the handler runs are double faults.
    assign sync_cause = (cause_step4 != CAUSE_NONE) || is_step3_event(cause_step3);

`ifdef EXC_VECTORED_EN
    assign handler_addr = HANDLER_ADDR + (PC_W'(cause_q) << 4);
`else
    assign handler_addr = HANDLER_ADDR;
`endif

    // State and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            epc_q   <= '0;
            cause_q <= CAUSE_NONE;
            df_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            df_q    <= df_d;
        end
    end

    // Next-state logic and per-state output decode.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        epc_d             = epc_q;
        cause_d           = cause_q;
        df_d              = df_q;
        interrupts_signal = 1'b0;
        flush_pipe        = 1'b0;
        pc_redirect       = 1'b0;
        pc_redirect_addr  = '0;
        in_handler        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    interrupts_signal = 1'b1;
                    flush_pipe        = 1'b1;
                    epc_d             = sel_epc;
                    cause_d           = sel_cause;
                    cnt_d             = FLUSH_INIT;
                    state_d           = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                interrupts_signal = 1'b1;
                flush_pipe        = 1'b1;
                if (cnt_q == 3'd0) begin
                    pc_redirect      = 1'b1;
                    pc_redirect_addr = handler_addr;
                    state_d          = ST_HANDLER;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_HANDLER: begin
                in_handler = 1'b1;
                if (sync_cause) begin
                    df_d = 1'b1;
                end
                if (eret) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                interrupts_signal = 1'b1;
                flush_pipe        = 1'b1;
                pc_redirect       = 1'b1;
                pc_redirect_addr  = epc_q;
                cause_d           = CAUSE_NONE;
                state_d           = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign epc          = epc_q;
    assign cause_reg    = cause_q;
    assign double_fault = df_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_exception_controller.sv
// Testbench for exception_controller: directed test-plan scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_exception_controller;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ext_irq;
    logic [2:0]  cause_step3;
    logic [31:0] pc_step3;
    logic        valid_step3;
    logic [2:0]  cause_step4;
    logic [31:0] pc_step4;
    logic        eret;
    logic        interrupts_signal;
    logic        flush_pipe;
    logic        pc_redirect;
    logic [31:0] pc_redirect_addr;
    logic [31:0] epc;
    logic [2:0]  cause_reg;
    logic        in_handler;
    logic        double_fault;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // Clock and DUT
    always #5 clk = ~clk;

    exception_controller #(.PC_W(32), .HANDLER_ADDR(32'h80), .FLUSH_CYCLES(FC)) dut (
        .clk               (clk),
        .reset             (reset),
        .ext_irq           (ext_irq),
        .cause_step3       (cause_step3),
        .pc_step3          (pc_step3),
        .valid_step3       (valid_step3),
        .cause_step4       (cause_step4),
        .pc_step4          (pc_step4),
        .eret              (eret),
        .interrupts_signal (interrupts_signal),
        .flush_pipe        (flush_pipe),
        .pc_redirect       (pc_redirect),
        .pc_redirect_addr  (pc_redirect_addr),
        .epc               (epc),
        .cause_reg         (cause_reg),
        .in_handler        (in_handler),
        .double_fault      (double_fault),
        .state_dbg         (state_dbg)
    );

    // Reference model: time since the last take, handler/return flags and
    // the saved architectural values.
    int          m_since_take;   // -1 when no take sequence is running
    bit          m_in_h;
    bit          m_ret;
    logic [31:0] m_epc;
    logic [2:0]  m_cause;
    bit          m_df;

    function automatic logic [31:0] m_handler(input logic [2:0] c);
`ifdef EXC_VECTORED_EN
        return 32'h80 + 32'(c) * 16;
`else
        return 32'h80;
`endif
    endfunction

    // Which event (if any) the rules pick from the current inputs.
    function automatic bit m_pick(output logic [2:0] c, output logic [31:0] e);
        c = 3'd4;
        e = 32'd0;
        if (cause_step4 != 3'd4) begin
            c = cause_step4; e = pc_step4; return 1'b1;
        end
        if (cause_step3 == 3'd1) begin
            c = 3'd1; e = pc_step3; return 1'b1;
        end
        if (cause_step3 == 3'd3) begin
            c = 3'd3; e = pc_step3 + 32'd4; return 1'b1;
        end
        if (ext_irq && valid_step3) begin
            c = 3'd0; e = pc_step3; return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_since_take = -1;
        m_in_h = 1'b0;
        m_ret = 1'b0;
        m_epc = 32'd0;
        m_cause = 3'd4;
        m_df = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare every output against the model,
    // then advance the model across the edge.
    task automatic drive(input bit rst, input bit irq, input logic [2:0] c3,
                         input logic [31:0] p3, input bit v3, input logic [2:0] c4,
                         input logic [31:0] p4, input bit er);
        logic [2:0]  pc_c;
        logic [31:0] pc_e;
        bit          tk;
        bit          e_int, e_flush, e_redir, e_inh;
        logic [31:0] e_addr;
        @(negedge clk);
        reset = rst; ext_irq = irq; cause_step3 = c3; pc_step3 = p3;
        valid_step3 = v3; cause_step4 = c4; pc_step4 = p4; eret = er;
        #1;
        tk = 1'b0;
        e_int = 1'b0; e_flush = 1'b0; e_redir = 1'b0; e_inh = 1'b0; e_addr = 32'd0;
        if (m_since_take > 0) begin
            e_int = 1'b1; e_flush = 1'b1;
            if (m_since_take == FC) begin
                e_redir = 1'b1; e_addr = m_handler(m_cause);
            end
        end else if (m_in_h) begin
            e_inh = 1'b1;
        end else if (m_ret) begin
            e_int = 1'b1; e_flush = 1'b1; e_redir = 1'b1; e_addr = m_epc;
        end else begin
            tk = m_pick(pc_c, pc_e);
            e_int = tk; e_flush = tk;
        end
        check("interrupts_signal", 32'(interrupts_signal), 32'(e_int));
        check("flush_pipe", 32'(flush_pipe), 32'(e_flush));
        check("pc_redirect", 32'(pc_redirect), 32'(e_redir));
        check("pc_redirect_addr", pc_redirect_addr, e_addr);
        check("in_handler", 32'(in_handler), 32'(e_inh));
        check("epc", epc, m_epc);
        check("cause_reg", 32'(cause_reg), 32'(m_cause));
        check("double_fault", 32'(double_fault), 32'(m_df));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_since_take > 0) begin
            if (m_since_take == FC) begin
                m_since_take = -1; m_in_h = 1'b1;
            end else begin
                m_since_take++;
            end
        end else if (m_in_h) begin
            if (c4 != 3'd4 || c3 == 3'd1 || c3 == 3'd3) m_df = 1'b1;
            if (er) begin
                m_in_h = 1'b0; m_ret = 1'b1;
            end
        end else if (m_ret) begin
            m_ret = 1'b0; m_cause = 3'd4;
        end else if (tk) begin
            m_epc = pc_e; m_cause = pc_c; m_since_take = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 3'd4, 32'h0, 0, 3'd4, 32'h0, 0);
    endtask

    task automatic do_eret();
        drive(0, 0, 3'd4, 32'h0, 0, 3'd4, 32'h0, 1);
        idle(1);
    endtask

    // Directed scenarios, then randomized traffic
    initial begin
        reset = 1'b1; ext_irq = 1'b0; cause_step3 = 3'd4; pc_step3 = '0;
        valid_step3 = 1'b0; cause_step4 = 3'd4; pc_step4 = '0; eret = 1'b0;
        model_reset();
        drive(1, 0, 3'd4, 32'h0, 0, 3'd4, 32'h0, 0);
        drive(1, 0, 3'd4, 32'h0, 0, 3'd4, 32'h0, 0);
        idle(1);
        check("reset_cause_reg", 32'(cause_reg), 32'h4);
        check("reset_epc", epc, 32'h0);

        // Overflow in execute stage
        drive(0, 0, 3'd4, 32'h0, 0, 3'd2, 32'h40, 0);
        idle(3);
        #1;
        check("tp1_epc", epc, 32'h40);
        check("tp1_cause", 32'(cause_reg), 32'h2);
        check("tp1_in_handler", 32'(in_handler), 32'h1);
        do_eret();

        // Simultaneous events: the oldest wins
        drive(0, 1, 3'd3, 32'h44, 1, 3'd2, 32'h40, 0);
        idle(3);
        #1;
        check("tp2_epc", epc, 32'h40);
        check("tp2_cause", 32'(cause_reg), 32'h2);
        do_eret();
        idle(1);

        // Syscall resumes at pc+4
        drive(0, 0, 3'd3, 32'h1C, 1, 3'd4, 32'h0, 0);
        idle(3);
        #1;
        check("tp3_epc", epc, 32'h20);
        do_eret();
        #1;
        check("tp3_cause_cleared", 32'(cause_reg), 32'h4);

        // External interrupt waits for a valid step3 instruction
        for (int i = 0; i < 3; i++) drive(0, 1, 3'd4, 32'h100, 0, 3'd4, 32'h0, 0);
        drive(0, 1, 3'd4, 32'h100, 1, 3'd4, 32'h0, 0);
        idle(3);
        #1;
        check("tp4_epc", epc, 32'h100);
        check("tp4_cause", 32'(cause_reg), 32'h0);

        // Double fault in handler, irq masked
        drive(0, 0, 3'd1, 32'h200, 1, 3'd4, 32'h0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 3'd4, 32'h204, 1, 3'd4, 32'h0, 0);
        #1;
        check("tp5_df", 32'(double_fault), 32'h1);
        check("tp5_epc", epc, 32'h100);
        check("tp5_in_handler", 32'(in_handler), 32'h1);
        do_eret();
        idle(1);
        #1;
        check("tp5_df_sticky", 32'(double_fault), 32'h1);

        // Reset during flush
        drive(0, 0, 3'd4, 32'h0, 0, 3'd2, 32'h300, 0);
        idle(1);
        drive(1, 0, 3'd4, 32'h0, 0, 3'd4, 32'h0, 0);
        idle(1);
        #1;
        check("tp6_cause", 32'(cause_reg), 32'h4);
        check("tp6_df", 32'(double_fault), 32'h0);
        check("tp6_epc", epc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [2:0] c3, c4;
            c3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
            c4 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
            drive(($urandom_range(0, 59) == 0), bit'($urandom_range(0, 1)), c3,
                  {$urandom_range(0, 32'hFFFF), 2'b00}, bit'($urandom_range(0, 1)), c4,
                  {$urandom_range(0, 32'hFFFF), 2'b00}, ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
